// File: rtl/shift_add_mult_ctrl.sv
// rtl/shift_add_mult_ctrl.sv - iterative shift-add unsigned multiplier with valid/ready handshakes
module shift_add_mult_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] P,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   mcand, mplier;
    logic [2*WIDTH-1:0] acc, acc_nxt, p_reg;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   addend, sum;
    logic               carry;

    function automatic logic [1:0] fa(input logic a, input logic b, input logic ci);
        fa = {(a & b) | (ci & (a ^ b)), a ^ b ^ ci};
    endfunction

    // One WIDTH-bit ripple chain of FA cells, reused on every iteration
    always_comb begin
        logic c;
        addend = mplier[0] ? mcand : '0;
        sum    = '0;
        c      = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            {c, sum[i]} = fa(acc[WIDTH+i], addend[i], c);
        end
        carry   = c;
        acc_nxt = {carry, sum, acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = CALC;
            CALC: begin
                if (abort)            state_nxt = IDLE;
                else if (cnt == '0)   state_nxt = DONE;
            end
            DONE: if (abort || out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        P         = p_reg;
    end

    // P is only loaded on the final iteration, so an abort leaves the previous product visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            p_reg  <= '0;
        end else begin
            if (state == IDLE && in_valid) begin
                mcand  <= A;
                mplier <= B;
                acc    <= '0;
                cnt    <= CNT_W'(WIDTH - 1);
            end else if (state == CALC && !abort) begin
                acc    <= acc_nxt;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
                if (cnt == '0) p_reg <= acc_nxt;
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// tb/tb_shift_add_mult_ctrl.sv - self-checking bench for shift_add_mult_ctrl
module tb_shift_add_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic        abort;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] P;
    logic        busy;

    int checks = 0;
    int errors = 0;

    shift_add_mult_ctrl #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .P(P), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        longint unsigned x;
        x = longint'(a) * longint'(b);
        return x[31:0];
    endfunction

    // Presents one operand pair; lat = cycles from presenting operands until out_valid seen
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [31:0] p, output int lat);
        lat = -1;
        p   = 'x;
        @(negedge clk);
        A = a; B = b; in_valid = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            if (i == 1) begin in_valid = 1'b0; A = 'x; B = 'x; end
            if (out_valid === 1'b1) begin lat = i; p = P; break; end
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        int lat;
        run_op(a, b, p, lat);
        checks++;
        if (lat !== 17) begin
            errors++;
            $display("FAIL %s latency got %0d want 17", name, lat);
        end
        checks++;
        if (p !== ref_mul(a, b)) begin
            errors++;
            $display("FAIL %s product got %h want %h", name, p, ref_mul(a, b));
        end
        consume();
    endtask

    task automatic test_reset();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100 || P !== 32'h0) begin
            errors++;
            $display("FAIL reset_state got rdy=%b vld=%b busy=%b P=%h want 1 0 0 0",
                     in_ready, out_valid, busy, P);
        end
    endtask

    task automatic test_basic();
        check_op("basic_3x5", 16'h0003, 16'h0005);
        checks++;
        if (ref_mul(16'h0003, 16'h0005) !== 32'h0000000F || P !== 32'h0000000F) begin
            errors++;
            $display("FAIL basic_const got %h want 0000000f", P);
        end
    endtask

    task automatic test_carry_and_edges();
        check_op("full_carry", 16'hFFFF, 16'hFFFF);
        checks++;
        if (P !== 32'hFFFE0001) begin
            errors++;
            $display("FAIL full_carry_const got %h want fffe0001", P);
        end
        check_op("zero_mcand", 16'h0000, 16'h1234);
        check_op("msb_shift", 16'h8000, 16'h0002);
        checks++;
        if (P !== 32'h00010000) begin
            errors++;
            $display("FAIL msb_shift_const got %h want 00010000", P);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] p;
        int lat;
        run_op(16'h0ABC, 16'h0123, p, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || P !== ref_mul(16'h0ABC, 16'h0123)) begin
                errors++;
                $display("FAIL backpressure_hold cyc %0d got vld=%b rdy=%b P=%h want 1 0 %h",
                         i, out_valid, in_ready, P, ref_mul(16'h0ABC, 16'h0123));
            end
        end
        consume();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_abort();
        bit seen = 0;
        @(negedge clk);
        A = 16'h1234; B = 16'h5678; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; A = 'x; B = 'x;
        repeat (7) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b rdy=%b vld=%b want 0 1 0", busy, in_ready, out_valid);
        end
        checks++;
        if (P !== ref_mul(16'h0ABC, 16'h0123)) begin
            errors++;
            $display("FAIL abort_p_hold got %h want %h", P, ref_mul(16'h0ABC, 16'h0123));
        end
        repeat (20) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL abort_no_output got out_valid=1 want 0");
        end
        check_op("after_abort", 16'h00FF, 16'h0101);
    endtask

    task automatic test_abort_priority();
        bit got = 0;
        @(negedge clk);
        A = 16'h0007; B = 16'h0009; in_valid = 1'b1; abort = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; abort = 1'b0; A = 'x; B = 'x;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle_accept got busy=%b want 1", busy);
        end
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = (out_valid === 1'b1);
        end
        abort = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0; out_ready = 1'b0;
        checks++;
        if (!got || in_ready !== 1'b1 || out_valid !== 1'b0 || P !== 32'd63) begin
            errors++;
            $display("FAIL abort_done_consume got seen=%b rdy=%b vld=%b P=%h want 1 1 0 0000003f",
                     got, in_ready, out_valid, P);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        A = 16'h1234; B = 16'h5678; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; A = 'x; B = 'x;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || P !== 32'h0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b vld=%b busy=%b P=%h want 1 0 0 0",
                     in_ready, out_valid, busy, P);
        end
        @(negedge clk);
        rst_n = 1'b1;
        check_op("after_reset", 16'h1234, 16'h5678);
        checks++;
        if (P !== 32'h06260060) begin
            errors++;
            $display("FAIL after_reset_const got %h want 06260060", P);
        end
    endtask

    task automatic test_random();
        logic [31:0] q[$];
        logic [15:0] a_cur, b_cur;
        logic [31:0] exp_p;
        int done = 0;
        int cyc = 0;
        a_cur = 16'($urandom);
        b_cur = 16'($urandom);
        while (done < 1000 && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            A = in_valid ? a_cur : 'x;
            B = in_valid ? b_cur : 'x;
            if (out_valid === 1'b1 && out_ready) begin
                exp_p = (q.size() != 0) ? q.pop_front() : 32'hxxxxxxxx;
                checks++;
                if (P !== exp_p) begin
                    errors++;
                    $display("FAIL random_product #%0d got %h want %h", done, P, exp_p);
                end
                done++;
            end
            if (in_valid && in_ready === 1'b1) begin
                checks++;
                if (q.size() != 0 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL random_overlap got pending=%0d busy=%b want 0 0", q.size(), busy);
                end
                q.push_back(ref_mul(a_cur, b_cur));
                a_cur = 16'($urandom);
                b_cur = 16'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; A = 'x; B = 'x;
        checks++;
        if (done != 1000) begin
            errors++;
            $display("FAIL random_timeout got %0d products want 1000", done);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        A = '0; B = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        test_basic();
        test_carry_and_edges();
        test_backpressure();
        test_abort();
        test_abort_priority();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
